// File: rtl/bch63326_serial_tx_if.sv
// ----------------------------------------------------------------------------
// bch63326_serial_tx_if : word-in / bit-out handshake bundle for the BCH(63,32) serial transmitter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bch63326_serial_tx_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_first;
  logic             ser_last;
  logic             busy;
  logic [CNT_W-1:0] cw_count;

  modport master (
    output data_in, data_valid, ser_ready,
    input  data_ready, ser_out, ser_valid, ser_first, ser_last, busy, cw_count
  );

  modport slave (
    input  data_in, data_valid, ser_ready,
    output data_ready, ser_out, ser_valid, ser_first, ser_last, busy, cw_count
  );
endinterface

`default_nettype wire

// File: rtl/bch63326_serial_tx.sv
// ----------------------------------------------------------------------------
// bch63326_serial_tx : 32 data bits then 31 LFSR parity bits, MSB-first, backpressured
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bch63326_serial_tx #(
  parameter logic [30:0] GEN_POLY = 31'h7FFF_FFFF,
  parameter int          CNT_W    = 16
) (
  input  wire                     clk,
  input  wire                     rst,
  bch63326_serial_tx_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      sh_q, sh_d;
  logic [30:0]      r_q, r_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] cw_q, cw_d;

  logic             data_ready;
  logic             ser_valid;
  logic             ser_bit;
  logic             ser_first;
  logic             ser_last;
  logic             fb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      cw_q    <= cw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    cw_d       = cw_q;
    data_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_bit    = 1'b0;
    ser_first  = 1'b0;
    ser_last   = 1'b0;
    fb         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ready is masked during reset so nothing is accepted in that cycle.
        data_ready = !rst;
        if (bus.data_valid && !rst) begin
          sh_d    = bus.data_in;
          r_d     = '0;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        ser_valid = 1'b1;
        ser_bit   = sh_q[31];
        ser_first = (cnt_q == 5'd0);
        if (bus.ser_ready) begin
          fb   = sh_q[31] ^ r_q[30];
          r_d  = {r_q[29:0], 1'b0} ^ (fb ? GEN_POLY : 31'd0);
          sh_d = {sh_q[30:0], 1'b0};
          if (cnt_q == 5'd31) begin
            cnt_d   = '0;
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      S_PARITY: begin
        ser_valid = 1'b1;
        ser_bit   = r_q[30];
        ser_last  = (cnt_q == 5'd30);
        if (bus.ser_ready) begin
          r_d = {r_q[29:0], 1'b0};
          if (cnt_q == 5'd30) begin
            cnt_d   = '0;
            cw_d    = cw_q + 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data_ready = data_ready;
  assign bus.ser_out    = ser_bit;
  assign bus.ser_valid  = ser_valid;
  assign bus.ser_first  = ser_first;
  assign bus.ser_last   = ser_last;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.cw_count   = cw_q;

endmodule

`default_nettype wire

// File: tb/tb_bch63326_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_bch63326_serial_tx : vector table, random backpressure, reset abort and counter wrap
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bch63326_serial_tx;

  localparam logic [30:0] GEN_POLY = 31'h7FFF_FFFF;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_cw;

  bch63326_serial_tx_if #(.CNT_W(16)) bus ();
  bch63326_serial_tx_if #(.CNT_W(2))  bus2 ();

  bch63326_serial_tx #(.GEN_POLY(GEN_POLY), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  bch63326_serial_tx #(.GEN_POLY(GEN_POLY), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] data;
    logic [30:0] parity;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain GF(2) long division of data*x^31 by the full degree-31 generator.
  function automatic logic [30:0] ref_parity(input logic [31:0] d);
    logic [62:0] m;
    logic [62:0] g;
    m = {d, 31'b0};
    g = {31'b0, 1'b1, GEN_POLY};
    for (int i = 62; i >= 31; i--)
      if (m[i]) m = m ^ (g << (i - 31));
    return m[30:0];
  endfunction

  task automatic send_word(input logic [31:0] d, input bit bp, output logic [62:0] cw);
    int   n, cyc, bad_valid, bad_flag, bad_hold, bad_ready;
    logic stalled;
    logic [2:0] held;
    bit   rdy;
    n = 0; cyc = 0; bad_valid = 0; bad_flag = 0; bad_hold = 0; bad_ready = 0;
    stalled = 1'b0; held = '0; cw = '0;

    @(negedge clk);
    check("accept_ready", {63'd0, bus.data_ready}, 64'd1);
    bus.data_in    = d;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.data_in    = $urandom;

    while (n < 63 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (!bus.ser_valid || !bus.busy) bad_valid++;
      if (bus.data_ready) bad_ready++;
      if (stalled && {bus.ser_out, bus.ser_first, bus.ser_last} !== held) bad_hold++;
      if (bus.ser_first !== (n == 0) || bus.ser_last !== (n == 62)) bad_flag++;
      rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.ser_ready = rdy;
      if (bp) begin
        bus.data_valid = ($urandom_range(0, 1) == 1);
        bus.data_in    = $urandom;
      end
      if (rdy) begin
        cw[62-n] = bus.ser_out;
        n++;
      end
      stalled = !rdy;
      held    = {bus.ser_out, bus.ser_first, bus.ser_last};
    end

    @(negedge clk);
    bus.data_valid = 1'b0;
    exp_cw = (exp_cw + 1) % 65536;
    check("bit_count",   64'(n), 64'd63);
    check("valid_hold",  64'(bad_valid), 64'd0);
    check("ready_busy",  64'(bad_ready), 64'd0);
    check("flags",       64'(bad_flag), 64'd0);
    check("stall_hold",  64'(bad_hold), 64'd0);
    if (!bp) check("cycles", 64'(cyc), 64'd63);
    check("done_ready",  {63'd0, bus.data_ready}, 64'd1);
    check("done_valid",  {62'd0, bus.ser_valid, bus.busy}, 64'd0);
    check("cw_count",    {48'd0, bus.cw_count}, 64'(exp_cw));
  endtask

  initial begin
    vec_t        vecs[5];
    logic [62:0] cw;
    logic [62:0] exp_w;
    logic [31:0] d;
    int          n, cyc, bad;

    checks = 0; errors = 0; exp_cw = 0;

    vecs[0] = '{32'h0000_0000, 31'h0000_0000};
    vecs[1] = '{32'h0000_0001, 31'h7FFF_FFFF};
    vecs[2] = '{32'h8000_0000, 31'h4000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 31'h0000_0000};
    vecs[4] = '{32'h0000_0002, 31'h0000_0001};

    rst = 1'b1;
    bus.data_in = '0;  bus.data_valid = 1'b0;  bus.ser_ready = 1'b1;
    bus2.data_in = '0; bus2.data_valid = 1'b0; bus2.ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, bus.data_ready}, 64'd0);
    check("rst_outs",  {59'd0, bus.ser_valid, bus.ser_out, bus.ser_first, bus.ser_last, bus.busy}, 64'd0);
    check("rst_cw",    {48'd0, bus.cw_count}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {63'd0, bus.data_ready}, 64'd1);

    foreach (vecs[i]) begin
      send_word(vecs[i].data, 1'b0, cw);
      check("vec_data",   64'(cw[62:31]), 64'(vecs[i].data));
      check("vec_parity", 64'(cw[30:0]),  64'(vecs[i].parity));
    end

    for (int k = 0; k < 200; k++) begin
      d = $urandom;
      send_word(d, 1'b1, cw);
      check("rand_cw", 64'(cw), 64'({d, ref_parity(d)}));
    end

    // Abort a codeword after 40 bits have left.
    d = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.data_in = d; bus.data_valid = 1'b1; bus.ser_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("pre_abort_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs",  {62'd0, bus.ser_valid, bus.busy}, 64'd0);
    check("abort_cw",    {48'd0, bus.cw_count}, 64'd0);
    check("abort_ready", {63'd0, bus.data_ready}, 64'd0);
    rst = 1'b0;
    exp_cw = 0;
    @(negedge clk);
    check("abort_ready_after", {63'd0, bus.data_ready}, 64'd1);
    d = $urandom;
    send_word(d, 1'b0, cw);
    check("after_abort_cw", 64'(cw), 64'({d, ref_parity(d)}));

    // Two-bit codeword counter with data_valid held high throughout.
    d = 32'hA5C3_0F1E;
    exp_w = {d, ref_parity(d)};
    @(negedge clk);
    bus2.data_in = d; bus2.data_valid = 1'b1; bus2.ser_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      n = 0; cyc = 0; bad = 0;
      while (n < 63 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (bus2.ser_valid) begin
          if (bus2.ser_out !== exp_w[62-n]) bad++;
          if (bus2.ser_first !== (n == 0) || bus2.ser_last !== (n == 62)) bad++;
          n++;
        end
      end
      check("wrap_bits", 64'(n), 64'd63);
      check("wrap_bad",  64'(bad), 64'd0);
      @(negedge clk);
      check("wrap_cw",    {62'd0, bus2.cw_count}, 64'(k % 4));
      check("wrap_ready", {63'd0, bus2.data_ready}, 64'd1);
    end
    bus2.data_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bch63326_serial_tx.md
# bch63326_serial_tx

Bit-serial transmitter for the 63-bit systematic code used by the codeword decoder. It accepts one 32-bit data word per codeword over a valid/ready handshake. It computes the 31 parity bits with a division LFSR while the data bits are being sent, then emits the full 63-bit codeword MSB-first on a backpressured serial stream. It sits on the transmit side of the link; the far end reassembles 63 bits and feeds the parallel decoder.

## Interface
- GEN_POLY, 31'h7FFF_FFFF, low 31 coefficients g30..g0 of the degree-31 generator; the x^31 term is implicit.
- CNT_W, 16, width of the codeword counter.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- data_in  in  32  data word; bit 31 is sent first.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  block can accept a word.
- ser_out  out  1  current codeword bit.
- ser_valid  out  1  ser_out is valid.
- ser_ready  in  1  downstream accepts ser_out.
- ser_first  out  1  ser_out is codeword bit 62.
- ser_last  out  1  ser_out is codeword bit 0.
- busy  out  1  a codeword is in flight (state != IDLE).
- cw_count  out  CNT_W  number of completed codewords; wraps modulo 2^CNT_W.

## Operation
- **Codeword layout:** bits [62:31] = data_in[31:0]; bits [30:0] = parity = remainder of data(x)·x^31 mod g(x). Transmission order is bit 62 down to bit 0.
- **States:** IDLE, DATA, PARITY.
- **IDLE:**
  - data_ready=1.
  - On data_valid&&data_ready: load shift register ← data_in, remainder r ← 0, bit counter ← 0, go to DATA.
- **Transfer:** one bit moves when ser_valid&&ser_ready ("xfer"). No state, counter or LFSR update occurs without xfer.
- **DATA (counter 0..31):**
  - ser_out = current data MSB.
  - On xfer: fb = ser_out ^ r[30]; r ← {r[29:0],1'b0} ^ (fb ? GEN_POLY : 0); shift data left; counter+1.
  - After the 32nd xfer, go to PARITY with counter ← 0.
- **PARITY (counter 0..30):**
  - ser_out = r[30].
  - On xfer: r ← {r[29:0],1'b0}; counter+1.
  - After the 31st xfer, go to IDLE and increment cw_count.
- **Flags:** ser_first=1 only in DATA with counter 0. ser_last=1 only in PARITY with counter 30.
- **Ignored input:** data_valid outside IDLE is ignored; data_in is sampled only at acceptance.
- **Width rules:**
  - The counter is 5 bits, which is enough for 0..31.
  - r is exactly 31 bits; the feedback term is the bit shifted out of r[30].
  - cw_count wraps from all-ones to 0 without a flag.

## Timing
- **Reset values:** data_ready=0 during the reset cycle and 1 in the first cycle after reset. ser_valid=0, ser_out=0, ser_first=0, ser_last=0, busy=0, cw_count=0. State=IDLE, r=0.
- **Latency:** the word is accepted in cycle T; ser_valid=1 with bit 62 (ser_first=1) in cycle T+1.
- **Throughput:** with ser_ready held high, bits 62..0 occupy cycles T+1..T+63, and data_ready=1 again in T+64. Minimum spacing is 64 cycles per codeword.
- **ser_valid:** stays 1 from T+1 through the cycle of the final xfer; it never drops mid-codeword.
- **Backpressure:** while ser_ready=0, ser_out, ser_first and ser_last hold their values.
- **cw_count:** updates in the cycle after the final xfer, which is the same cycle data_ready rises.
- **Reset mid-codeword:** the codeword is aborted. All outputs take their reset values in the next cycle, no partial codeword is completed, and cw_count is cleared.
- **ser_ready without ser_valid:** has no effect.

## Test plan
- **Zero word:** data_in=32'h0000_0000, ser_ready=1 → 63 zero bits; ser_first at T+1, ser_last at T+63; cw_count=1.
- **Single LSB:** data_in=32'h0000_0001 → data bits 31×0 then 1; parity 31'h7FFF_FFFF (31 ones).
- **Single MSB:** data_in=32'h8000_0000 → first bit 1, next 31 bits 0; parity 31'h4000_0000 (a single 1 immediately after the data, then 30 zeros).
- **Random backpressure:** 200 random words with ser_ready randomly toggled (~50%) → each reassembled codeword matches a reference model (GF(2) long division by GEN_POLY); ser_out stable whenever ser_ready=0; data_ready=0 while busy.
- **Reset mid-codeword:** assert rst after 40 xfers → next cycle ser_valid=0, busy=0, cw_count=0, data_ready=1 one cycle after rst deasserts; the following word encodes correctly from bit 62.
- **Counter wrap:** CNT_W=2, send 5 codewords back-to-back → cw_count sequence 1,2,3,0,1; data_valid held high while busy does not cause double acceptance.
